// File: rtl/apb_pkg.sv
// Shared definitions for the APB command master and its timeout counter:
// FSM state encoding, I/O slave register offsets and the word-alignment mask.
package apb_pkg;

   localparam logic [2:0] ST_IDLE    = 3'd0;
   localparam logic [2:0] ST_SETUP   = 3'd1;
   localparam logic [2:0] ST_ACCESS  = 3'd2;
   localparam logic [2:0] ST_CAPTURE = 3'd3;
   localparam logic [2:0] ST_RESP    = 3'd4;

   typedef enum logic [2:0] {
      IDLE    = ST_IDLE,
      SETUP   = ST_SETUP,
      ACCESS  = ST_ACCESS,
      CAPTURE = ST_CAPTURE,
      RESP    = ST_RESP
   } apb_state_e;

   localparam logic [3:0] STATUS32 = 4'h0;
   localparam logic [3:0] CTRL32   = 4'h4;
   localparam logic [3:0] CTRL16   = 4'h8;
   localparam logic [3:0] CTRL8    = 4'hC;

   localparam logic [1:0] ALIGN_MASK = 2'b11;

endpackage

// File: rtl/apb_timeout_counter.sv
// Counts ACCESS cycles; expired_o flags the cycle that is the TIMEOUT_CYCLES-th
// consecutive enabled cycle since the last clear.
module apb_timeout_counter #(
   parameter int TIMEOUT_CYCLES = 16
) (
   input  logic clk_i,
   input  logic rst_i,
   input  logic clr_i,
   input  logic en_i,
   output logic expired_o
);

   localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;

   // The current cycle is the last allowed one when the count already holds TIMEOUT_CYCLES-1.
   assign expired_o = en_i && (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

   always_comb begin
      cnt_d = cnt_q;
      if (clr_i)
         cnt_d = '0;
      else if (en_i && (cnt_q != CNT_W'(TIMEOUT_CYCLES)))
         cnt_d = cnt_q + CNT_W'(1);
   end

   always_ff @(posedge clk_i) begin
      if (rst_i)
         cnt_q <= '0;
      else
         cnt_q <= cnt_d;
   end

endmodule

// File: rtl/apb_cmd_master.sv
// APB3 requester: turns a valid/ready command stream into SETUP/ACCESS transfers
// and returns read data / error on a valid/ready response channel.
module apb_cmd_master
   import apb_pkg::*;
#(
   parameter int APB_ADDR_WIDTH = 4,
   parameter int APB_DATA_WIDTH = 32,
   parameter int TIMEOUT_CYCLES = 16,
   parameter int READ_DATA_LAG  = 1
) (
   input  logic                      PCLK,
   input  logic                      PRESET,
   input  logic                      cmd_valid_i,
   output logic                      cmd_ready_o,
   input  logic                      cmd_write_i,
   input  logic [APB_ADDR_WIDTH-1:0] cmd_addr_i,
   input  logic [APB_DATA_WIDTH-1:0] cmd_wdata_i,
   output logic                      rsp_valid_o,
   input  logic                      rsp_ready_i,
   output logic [APB_DATA_WIDTH-1:0] rsp_rdata_o,
   output logic                      rsp_err_o,
   output logic                      PSEL,
   output logic                      PENABLE,
   output logic                      PWRITE,
   output logic [APB_ADDR_WIDTH-1:0] PADDR,
   output logic [APB_DATA_WIDTH-1:0] PWDATA,
   input  logic [APB_DATA_WIDTH-1:0] PRDATA,
   input  logic                      PREADY,
   input  logic                      PSLVERR
);

   apb_state_e                state_q;
   logic                      psel_q;
   logic                      penable_q;
   logic                      pwrite_q;
   logic [APB_ADDR_WIDTH-1:0] paddr_q;
   logic [APB_DATA_WIDTH-1:0] pwdata_q;
   logic                      rsp_valid_q;
   logic [APB_DATA_WIDTH-1:0] rsp_rdata_q;
   logic                      rsp_err_q;

   logic accept;
   logic misaligned;
   logic to_clr;
   logic to_expired;

   assign cmd_ready_o = (state_q == IDLE) && !PRESET;
   assign accept      = cmd_valid_i && cmd_ready_o;
   assign misaligned  = (cmd_addr_i[1:0] & ALIGN_MASK) != 2'b00;
   assign to_clr      = accept && !misaligned;

   apb_timeout_counter #(
      .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
   ) u_timeout (
      .clk_i    (PCLK),
      .rst_i    (PRESET),
      .clr_i    (to_clr),
      .en_i     (state_q == ACCESS),
      .expired_o(to_expired)
   );

   always_ff @(posedge PCLK) begin
      if (PRESET) begin
         state_q     <= IDLE;
         psel_q      <= 1'b0;
         penable_q   <= 1'b0;
         pwrite_q    <= 1'b0;
         paddr_q     <= '0;
         pwdata_q    <= '0;
         rsp_valid_q <= 1'b0;
         rsp_rdata_q <= '0;
         rsp_err_q   <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (accept) begin
                  if (misaligned) begin
                     // Rejected locally: no bus cycle, immediate error response.
                     rsp_valid_q <= 1'b1;
                     rsp_err_q   <= 1'b1;
                     rsp_rdata_q <= '0;
                     state_q     <= RESP;
                  end else begin
                     pwrite_q  <= cmd_write_i;
                     paddr_q   <= cmd_addr_i;
                     pwdata_q  <= cmd_wdata_i;
                     psel_q    <= 1'b1;
                     penable_q <= 1'b0;
                     state_q   <= SETUP;
                  end
               end
            end
            SETUP: begin
               penable_q <= 1'b1;
               state_q   <= ACCESS;
            end
            ACCESS: begin
               if (PREADY) begin
                  psel_q    <= 1'b0;
                  penable_q <= 1'b0;
                  rsp_err_q <= PSLVERR;
                  if (!pwrite_q && (READ_DATA_LAG != 0)) begin
                     state_q <= CAPTURE;
                  end else begin
                     rsp_valid_q <= 1'b1;
                     rsp_rdata_q <= pwrite_q ? '0 : PRDATA;
                     state_q     <= RESP;
                  end
               end else if (to_expired) begin
                  psel_q      <= 1'b0;
                  penable_q   <= 1'b0;
                  rsp_valid_q <= 1'b1;
                  rsp_err_q   <= 1'b1;
                  rsp_rdata_q <= '0;
                  state_q     <= RESP;
               end
            end
            CAPTURE: begin
               // Registered-PRDATA slaves present read data one cycle late.
               rsp_rdata_q <= PRDATA;
               rsp_valid_q <= 1'b1;
               state_q     <= RESP;
            end
            RESP: begin
               if (rsp_ready_i) begin
                  rsp_valid_q <= 1'b0;
                  state_q     <= IDLE;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign PSEL        = psel_q;
   assign PENABLE     = penable_q;
   assign PWRITE      = pwrite_q;
   assign PADDR       = paddr_q;
   assign PWDATA      = pwdata_q;
   assign rsp_valid_o = rsp_valid_q;
   assign rsp_rdata_o = rsp_rdata_q;
   assign rsp_err_o   = rsp_err_q;

endmodule

// File: doc/apb_cmd_master.md
Name: apb_cmd_master

Overview:
APB3 requester placed directly upstream of the APB I/O register slave. It converts a valid/ready command stream from the system controller into APB SETUP/ACCESS transfers, waits for PREADY, and returns read data and an error flag on a valid/ready response channel. It also handles two failure cases: a slave that never asserts PREADY (timeout) and slaves whose PRDATA is registered (data valid one cycle after the access phase).

Parameters:
APB_ADDR_WIDTH, 4, width of PADDR and cmd_addr_i
APB_DATA_WIDTH, 32, width of PWDATA/PRDATA and the command/response data
TIMEOUT_CYCLES, 16, maximum ACCESS cycles waiting for PREADY; range 1..255
READ_DATA_LAG, 1, 0 = sample PRDATA in the PREADY cycle; 1 = sample PRDATA one cycle after the PREADY cycle

Ports:
PCLK  in  1  clock
PRESET  in  1  synchronous, active-high reset
cmd_valid_i  in  1  command valid
cmd_ready_o  out  1  command accepted when valid & ready
cmd_write_i  in  1  1 = write, 0 = read
cmd_addr_i  in  APB_ADDR_WIDTH  byte address
cmd_wdata_i  in  APB_DATA_WIDTH  write data
rsp_valid_o  out  1  response valid
rsp_ready_i  in  1  response consumed when valid & ready
rsp_rdata_o  out  APB_DATA_WIDTH  read data; 0 for writes and errors
rsp_err_o  out  1  PSLVERR, timeout or misaligned address
PSEL  out  1  APB select
PENABLE  out  1  APB enable
PWRITE  out  1  APB direction
PADDR  out  APB_ADDR_WIDTH  APB address
PWDATA  out  APB_DATA_WIDTH  APB write data
PRDATA  in  APB_DATA_WIDTH  APB read data
PREADY  in  1  APB ready
PSLVERR  in  1  APB slave error

Behaviour:
- Clocking and reset: one clock, PCLK. Reset PRESET is synchronous and active-high.
- Reset values: PSEL, PENABLE, PWRITE, rsp_valid_o and rsp_err_o = 0; PADDR, PWDATA and rsp_rdata_o = 0; cmd_ready_o = 0 while PRESET = 1; state = IDLE.
- All APB and response outputs are registered. cmd_ready_o = (state == IDLE) and not PRESET.
- FSM states: IDLE, SETUP, ACCESS, CAPTURE, RESP.
  - IDLE: on cmd_valid_i & cmd_ready_o, latch write/addr/wdata.
    - If addr[1:0] != 0, go to RESP with err = 1 and rdata = 0; no APB transfer is issued.
    - Otherwise go to SETUP.
  - SETUP: exactly 1 cycle with PSEL = 1, PENABLE = 0; PADDR/PWRITE/PWDATA driven from the latched command. Go to ACCESS.
  - ACCESS: PSEL = 1, PENABLE = 1; the timeout counter increments each cycle.
    - PREADY = 1: capture PSLVERR into err. Go to CAPTURE if this is a read and READ_DATA_LAG = 1; otherwise go to RESP (read with lag 0: rdata = PRDATA).
    - PREADY = 0 when the counter reaches TIMEOUT_CYCLES: err = 1, rdata = 0, go to RESP.
    - PSEL and PENABLE deassert on the cycle after the terminating cycle.
  - CAPTURE: 1 cycle, PSEL = PENABLE = 0; rdata = PRDATA. Go to RESP.
  - RESP: rsp_valid_o = 1; rsp_rdata_o and rsp_err_o held stable until rsp_ready_i; on handshake go to IDLE.
- Latency with a zero-wait slave: command accepted at cycle 0, SETUP at cycle 1, ACCESS at cycle 2, rsp_valid_o at cycle 3 (write or lag-0 read) or cycle 4 (lag-1 read).
- Throughput: one outstanding command; no new command is accepted until the response handshake completes.
- rsp_rdata_o is forced to 0 for writes. PSLVERR on a read still reports the sampled data, with err = 1.
- The timeout counter clears on entry to SETUP. Its width is ceil(log2(TIMEOUT_CYCLES + 1)).
- PADDR/PWDATA hold their last values when idle; PWRITE holds its last value.
- Reset mid-operation: on the edge with PRESET = 1, the FSM returns to IDLE, PSEL/PENABLE drop, and the command is discarded with no response issued.
- rsp_ready_i held 0 indefinitely: the block stalls in RESP with outputs stable.

Decomposition:
- Shared package apb_pkg:
  - FSM state encoding (3-bit localparams).
  - APB register offset constants for the I/O slave: STATUS32 = 0x0, CTRL32 = 0x4, CTRL16 = 0x8, CTRL8 = 0xC.
  - Word-alignment mask constant ALIGN_MASK = 2'b11.
- One sub-module, apb_timeout_counter: clear/enable/expired, parameterised by TIMEOUT_CYCLES.

Test Plan:
1. Write then read, against the I/O register slave (READ_DATA_LAG = 1): write 0x4 = 0xDEADBEEF, then read 0x4 -> write rsp err = 0, rdata = 0; read rsp rdata = 0xDEADBEEF, err = 0, rsp_valid_o at cycle 4 after acceptance.
2. Composite read: write 0x8 = 0x0000A5A5 with status16b_i = 0x1234, then read 0x8 -> rdata = 0x1234A5A5.
3. Timeout: slave PREADY tied 0, TIMEOUT_CYCLES = 4, read 0x0 -> exactly 4 ACCESS cycles, then rsp err = 1, rdata = 0; PSEL = 0 on the following cycle.
4. Misaligned address: command addr 0x6 -> PSEL never asserts; rsp_valid_o 1 cycle after acceptance with err = 1.
5. Response backpressure and slave error: PSLVERR = 1 on a write with rsp_ready_i = 0 for 5 cycles -> rsp_valid_o and err = 1 held stable; cmd_ready_o = 0 throughout; returns to IDLE after the handshake.
6. Reset mid-operation: assert PRESET during ACCESS -> next cycle PSEL = PENABLE = rsp_valid_o = 0; after release, a read of 0x0 with status32b_i = 0x0BADF00D returns 0x0BADF00D.
